// File: rtl/mult_unit.sv
// mult_unit: 32x32 radix-2 shift-add multiplier writing the HI/LO register pair.
module mult_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        mult_sign,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state_q, state_d;
  logic [63:0] mcand_q, mcand_d, acc_q, acc_d, sum, res;
  logic [31:0] mplier_q, mplier_d, hi_q, hi_d, lo_q, lo_d, mag_a, mag_b;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d, busy_q, busy_d, done_q, done_d, accept;
  always_comb begin
    mag_a    = (mult_sign && operand_a[31]) ? -operand_a : operand_a;
    mag_b    = (mult_sign && operand_b[31]) ? -operand_b : operand_b;
    accept   = start_mult && state_q != RUN;
    sum      = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
    res      = neg_q ? -sum : sum;
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (accept) begin
      state_d  = RUN;
      mcand_d  = {32'd0, mag_a};
      mplier_d = mag_b;
      neg_d    = mult_sign && (operand_a[31] ^ operand_b[31]);
      acc_d    = 64'd0;
      cnt_d    = 5'd0;
      busy_d   = 1'b1;
    end else if (state_q == RUN) begin
      acc_d    = sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 5'd1;
      // counter wrapping 31 -> 0 is the last multiplier bit
      if (cnt_q == 5'd31) begin
        {hi_d, lo_d} = res;
        done_d       = 1'b1;
        busy_d       = 1'b0;
        state_d      = DONE;
      end
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      acc_q    <= 64'd0;
      cnt_q    <= 5'd0;
      neg_q    <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit: random and directed multiplies checked against an arithmetic product model via a scoreboard.
module tb_mult_unit;
  logic        clk = 1'b0, reset = 1'b1, start_mult = 1'b0, mult_sign = 1'b0;
  logic [31:0] operand_a = '0, operand_b = '0, hi, lo;
  logic        busy, done, r_q;
  logic [63:0] sb[$];
  logic [63:0] held = '0, exp_v;
  int          checks = 0, errors = 0, bcnt = 0;
  logic        prev_done = 1'b0;
  mult_unit dut (
    .clk(clk), .reset(reset), .start_mult(start_mult), .mult_sign(mult_sign),
    .operand_a(operand_a), .operand_b(operand_b), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) r_q <= reset;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    sp = longint'($signed(a)) * longint'($signed(b));
    up = longint'(a) * longint'(b);
    return s ? 64'(sp) : 64'(up);
  endfunction
  // monitor: pops an expected product on every done pulse; otherwise hi/lo must hold
  initial forever begin
    @(negedge clk);
    if (r_q === 1'b1) begin
      sb.delete();
      held = '0;
    end
    if (done) begin
      if (sb.size() == 0) chk("unexpected_done", {hi, lo}, held);
      else begin
        exp_v = sb.pop_front();
        chk("product", {hi, lo}, exp_v);
        held = exp_v;
      end
      if (prev_done) chk("done_width", 64'(prev_done && done), 64'd0);
    end else if (r_q !== 1'bx) chk("hold", {hi, lo}, held);
    if (busy) bcnt++;
    else if (bcnt != 0) begin
      if (r_q !== 1'b1) chk("busy_len", 64'(bcnt), 64'd32);
      bcnt = 0;
    end
    prev_done = done;
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic mult(input bit s, input logic [31:0] a, input logic [31:0] b, input bit spur, input bit abort);
    mult_sign = s; operand_a = a; operand_b = b; start_mult = 1'b1;
    cyc();
    start_mult = 1'b0;
    if (!abort) sb.push_back(model(s, a, b));
    chk("busy_start", 64'(busy), 64'd1);
    operand_a = $urandom; operand_b = $urandom; mult_sign = 1'($urandom);
    for (int i = 1; i <= 32; i++) begin
      if (abort && i == 16) begin
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        return;
      end
      start_mult = spur && i == 10;
      if (start_mult) begin operand_a = 32'd7; operand_b = 32'd7; end
      cyc();
      start_mult = 1'b0;
      if (i < 32) chk("busy_run", 64'(busy), 64'd1);
    end
    chk("done_latency", 64'(done), 64'd1);
    chk("busy_end", 64'(busy), 64'd0);
  endtask
  initial begin
    cyc();
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    start_mult = 1'b1;
    cyc();
    reset = 1'b0;
    start_mult = 1'b0;
    chk("rst_override", 64'(busy), 64'd0);
    cyc();
    mult(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    cyc();
    mult(1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    mult(1'b1, 32'h80000000, 32'h80000000, 1'b0, 1'b0);
    cyc(); cyc();
    mult(1'b1, 32'd3, -32'sd5, 1'b1, 1'b0);
    mult(1'b0, 32'd2, 32'd3, 1'b0, 1'b0);
    cyc();
    mult(1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1);
    cyc();
    mult(1'b0, 32'd0, 32'h12345678, 1'b0, 1'b0);
    for (int k = 0; k < 30; k++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      if (k % 5 == 0) a = 32'h80000000;
      if (k % 7 == 3) b = 32'd0;
      mult(1'($urandom), a, b, 1'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) cyc();
    end
    repeat (4) cyc();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_unit.md
MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port: start_mult  input  1  control-unit request to begin a multiply (MULT/MULTU).
REQ-005 Port: mult_sign  input  1  1 = signed (MULT), 0 = unsigned (MULTU); sampled together with start_mult.
REQ-006 Port: operand_a  input  32  rs value; sampled together with start_mult.
REQ-007 Port: operand_b  input  32  rt value; sampled together with start_mult.
REQ-008 Port: hi  output  32  HI register, product bits [63:32], read by MFHI.
REQ-009 Port: lo  output  32  LO register, product bits [31:0], read by MFLO.
REQ-010 Port: busy  output  1  multiply in progress; the hazard unit stalls MFHI/MFLO while busy is high.
REQ-011 Port: done  output  1  one-cycle pulse when hi/lo have just been updated.

Function
REQ-012 The block SHALL be an FSM with states IDLE, RUN and DONE, and all outputs SHALL be registered.
REQ-013 In IDLE or DONE, start_mult=1 at a clock edge SHALL do the following at that edge:
- latch the operand magnitudes and the result sign;
- clear the 64-bit accumulator and the 5-bit iteration counter;
- enter RUN.
REQ-014 Signed mode: each latched magnitude is the absolute value of its operand; result sign = operand_a[31] XOR operand_b[31]. Unsigned mode: the magnitudes are the raw operands and the result sign = 0.
REQ-015 A magnitude of 0x80000000 (from -2^31) SHALL be handled as the unsigned value 2^31, with no overflow.
REQ-016 Each RUN cycle SHALL process one multiplier bit (shift-add radix-2): if the current bit is 1, add the shifted multiplicand to the accumulator, then increment the counter.
REQ-017 RUN SHALL last exactly 32 edges; counter wrap from 31 to 0 marks the final iteration.
REQ-018 On the final RUN edge the block SHALL do all of the following:
- write {hi,lo} with the accumulator, or its 64-bit two's-complement negation when the result sign is 1;
- set done=1;
- set busy=0;
- enter DONE.
REQ-019 busy SHALL be 1 for exactly 32 cycles, starting the cycle after start_mult is accepted; done SHALL follow in the next cycle.
REQ-020 Latency: hi/lo SHALL be valid and done=1 in the 33rd cycle after the accepting edge (accepting edge = E0, result edge = E32).
REQ-021 From DONE the block SHALL return to IDLE on the next edge unless start_mult=1 (REQ-013); done is high for exactly one cycle per multiply.
REQ-022 start_mult=1 while in RUN SHALL be ignored: operands are not re-latched and the counter is not restarted.
REQ-023 hi/lo SHALL hold their previous values throughout RUN and change only at the REQ-018 edge.
REQ-024 mult_sign and operand changes after the accepting edge SHALL have no effect on the running multiply.
REQ-025 A zero operand SHALL still take the full 32 cycles; there is no early termination.

Reset
REQ-026 reset=1 at an edge SHALL force the following, overriding start_mult:
- state = IDLE;
- hi = 0x00000000 and lo = 0x00000000;
- busy = 0 and done = 0;
- counter = 0 and accumulator = 0.
REQ-027 reset asserted mid-RUN SHALL abort the multiply with no hi/lo update and no done pulse. The first start_mult after reset deasserts SHALL be accepted normally.

Verification
REQ-028 Unsigned: MULTU, a=0xFFFFFFFF, b=0xFFFFFFFF -> busy high for 32 cycles, then done pulse; hi=0xFFFFFFFE, lo=0x00000001.
REQ-029 Signed: MULT, a=0xFFFFFFFF (-1), b=0x00000001 -> hi=0xFFFFFFFF, lo=0xFFFFFFFF. Also MULT, a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-030 Ignored restart: MULT a=3, b=-5, with start_mult re-pulsed at cycle 10 using a=7, b=7 -> done still at cycle 33; hi=0xFFFFFFFF, lo=0xFFFFFFF1 (-15); busy never extends past 32 cycles.
REQ-031 Back-to-back: start_mult=1 in the DONE cycle (a=2, b=3, MULTU) -> accepted with no IDLE gap; the new done pulse arrives 33 cycles later with hi=0, lo=6; hi/lo keep the first result until then.
REQ-032 Reset mid-operation: reset at cycle 15 of RUN -> hi=lo=0, busy=0, done never pulses. A following MULTU a=0, b=0x12345678 -> full 32 busy cycles, then hi=lo=0.
